// File: rtl/ex_mem_reg.sv
// E->M pipeline register: classifies ALU results into Ov/AdEL/AdES exception codes.
// Optional address-map fault checking is enabled by defining ADDR_RANGE_CHECK_EN.
module ex_mem_reg #(
  parameter logic [31:0] DM_END   = 32'h0000_2FFF,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] e_pc,
  input  logic        e_bd,
  input  logic [4:0]  e_exc,
  input  logic [31:0] e_alu_res,
  input  logic        e_alu_ov,
  input  logic        e_arith_ov,
  input  logic        e_load,
  input  logic        e_store,
  input  logic [1:0]  e_width,
  input  logic [31:0] e_st_data,
  input  logic [4:0]  e_rd_addr,
  output logic [31:0] m_pc,
  output logic        m_bd,
  output logic [4:0]  m_exc,
  output logic [31:0] m_alu_res,
  output logic        m_load,
  output logic        m_store,
  output logic [1:0]  m_width,
  output logic [31:0] m_st_data,
  output logic [4:0]  m_rd_addr,
  output logic        m_mem_we,
  output logic        m_rf_we
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

`ifdef ADDR_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  // Natural alignment: words on 4 bytes, halves on 2, bytes anywhere.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
    logic bad;
    case (width)
      2'd0:    bad = (lsb != 2'd0);
      2'd1:    bad = lsb[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && (addr <= base + size - 32'd1);
  endfunction

  // Address map fault: unmapped, sub-word timer access, or a write to a timer count.
  function automatic logic addr_fault(input logic is_store, input logic [1:0] width,
                                      input logic [31:0] addr);
    logic in_dm;
    logic in_tc;
    logic in_ig;
    logic bad;
    in_dm = (addr <= DM_END);
    in_tc = in_window(addr, TC0_BASE, 32'd12) || in_window(addr, TC1_BASE, 32'd12);
    in_ig = in_window(addr, IG_BASE, 32'd4);
    bad   = 1'b0;
    if (!(in_dm || in_tc || in_ig)) begin
      bad = 1'b1;
    end else if (in_tc && (width != 2'd0)) begin
      bad = 1'b1;
    end else if (is_store && ((addr == TC0_BASE + 32'd8) || (addr == TC1_BASE + 32'd8))) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  function automatic logic [4:0] classify_exc(
    input logic [4:0]  exc_in,
    input logic        arith_ov,
    input logic        alu_ov,
    input logic        is_load,
    input logic        is_store,
    input logic [1:0]  width,
    input logic [31:0] addr
  );
    logic       mem;
    logic [4:0] fault;
    logic [4:0] code;
    mem   = is_load | is_store;
    fault = is_load ? EXC_ADEL : EXC_ADES;
    if (exc_in != EXC_NONE) begin
      code = exc_in;
    end else if (arith_ov && alu_ov) begin
      code = EXC_OV;
    end else if (mem && alu_ov) begin
      code = fault;
    end else if (mem && misaligned(width, addr[1:0])) begin
      code = fault;
    end else if (RANGE_CHECK && mem && addr_fault(is_store, width, addr)) begin
      code = fault;
    end else begin
      code = EXC_NONE;
    end
    return code;
  endfunction

  logic [31:0] pc_q,     pc_d;
  logic        bd_q,     bd_d;
  logic [4:0]  exc_q,    exc_d;
  logic [31:0] res_q,    res_d;
  logic        load_q,   load_d;
  logic        store_q,  store_d;
  logic [1:0]  width_q,  width_d;
  logic [31:0] sdata_q,  sdata_d;
  logic [4:0]  rd_q,     rd_d;
  logic        mem_we_q, mem_we_d;
  logic        rf_we_q,  rf_we_d;

  logic        store_only_s;
  logic [4:0]  exc_new_s;

  // A simultaneous load+store is treated as a load, so the store bit is dropped.
  assign store_only_s = e_store & ~e_load;
  assign exc_new_s    = classify_exc(e_exc, e_arith_ov, e_alu_ov, e_load, store_only_s,
                                     e_width, e_alu_res);

  // Next-state selection: flush inserts a bubble, stall holds, otherwise capture.
  always_comb begin
    pc_d     = pc_q;
    bd_d     = bd_q;
    exc_d    = exc_q;
    res_d    = res_q;
    load_d   = load_q;
    store_d  = store_q;
    width_d  = width_q;
    sdata_d  = sdata_q;
    rd_d     = rd_q;
    mem_we_d = mem_we_q;
    rf_we_d  = rf_we_q;
    if (flush) begin
      pc_d     = 32'd0;
      bd_d     = 1'b0;
      exc_d    = EXC_NONE;
      res_d    = 32'd0;
      load_d   = 1'b0;
      store_d  = 1'b0;
      width_d  = 2'd0;
      sdata_d  = 32'd0;
      rd_d     = 5'd0;
      mem_we_d = 1'b0;
      rf_we_d  = 1'b0;
    end else if (!stall) begin
      pc_d     = e_pc;
      bd_d     = e_bd;
      exc_d    = exc_new_s;
      res_d    = e_alu_res;
      load_d   = e_load;
      store_d  = store_only_s;
      width_d  = e_width;
      sdata_d  = e_st_data;
      rd_d     = e_rd_addr;
      mem_we_d = store_only_s && (exc_new_s == EXC_NONE);
      rf_we_d  = (e_rd_addr != 5'd0) && (exc_new_s == EXC_NONE);
    end else begin
      pc_d = pc_q;
    end
  end

  // Pipeline register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= 32'd0;
      bd_q     <= 1'b0;
      exc_q    <= EXC_NONE;
      res_q    <= 32'd0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      width_q  <= 2'd0;
      sdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      mem_we_q <= 1'b0;
      rf_we_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      bd_q     <= bd_d;
      exc_q    <= exc_d;
      res_q    <= res_d;
      load_q   <= load_d;
      store_q  <= store_d;
      width_q  <= width_d;
      sdata_q  <= sdata_d;
      rd_q     <= rd_d;
      mem_we_q <= mem_we_d;
      rf_we_q  <= rf_we_d;
    end
  end

  assign m_pc      = pc_q;
  assign m_bd      = bd_q;
  assign m_exc     = exc_q;
  assign m_alu_res = res_q;
  assign m_load    = load_q;
  assign m_store   = store_q;
  assign m_width   = width_q;
  assign m_st_data = sdata_q;
  assign m_rd_addr = rd_q;
  assign m_mem_we  = mem_we_q;
  assign m_rf_we   = rf_we_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed cases plus randomized traffic
// against a behavioural model of the exception rules and update priority.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] e_pc, e_alu_res, e_st_data;
  logic        e_bd, e_alu_ov, e_arith_ov, e_load, e_store;
  logic [4:0]  e_exc, e_rd_addr;
  logic [1:0]  e_width;
  logic [31:0] m_pc, m_alu_res, m_st_data;
  logic        m_bd, m_load, m_store, m_mem_we, m_rf_we;
  logic [4:0]  m_exc, m_rd_addr;
  logic [1:0]  m_width;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the expected M-stage bundle.
  logic [31:0] x_pc, x_res, x_sd;
  logic        x_bd, x_load, x_store, x_mwe, x_rwe;
  logic [4:0]  x_exc, x_rd;
  logic [1:0]  x_width;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .e_pc(e_pc), .e_bd(e_bd), .e_exc(e_exc), .e_alu_res(e_alu_res),
    .e_alu_ov(e_alu_ov), .e_arith_ov(e_arith_ov), .e_load(e_load), .e_store(e_store),
    .e_width(e_width), .e_st_data(e_st_data), .e_rd_addr(e_rd_addr),
    .m_pc(m_pc), .m_bd(m_bd), .m_exc(m_exc), .m_alu_res(m_alu_res),
    .m_load(m_load), .m_store(m_store), .m_width(m_width), .m_st_data(m_st_data),
    .m_rd_addr(m_rd_addr), .m_mem_we(m_mem_we), .m_rf_we(m_rf_we)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input bit is_store, input int unsigned width,
                                 input int unsigned a);
    bit dm, tc, ig;
    dm = (a <= 32'h2FFF);
    tc = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
    ig = (a >= 32'h7F20 && a < 32'h7F24);
    if (!(dm || tc || ig)) return 1'b0;
    if (tc && width != 0) return 1'b0;
    if (is_store && (a == 32'h7F08 || a == 32'h7F18)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned model_exc();
    bit mem, is_st;
    int unsigned fault, a, w;
    mem   = e_load || e_store;
    is_st = e_store && !e_load;
    fault = e_load ? 4 : 5;
    a     = e_alu_res;
    w     = e_width;
    if (e_exc != 0) return e_exc;
    if (e_arith_ov && e_alu_ov) return 12;
    if (mem && e_alu_ov) return fault;
    if (mem && ((w == 0 && a % 4 != 0) || (w == 1 && a % 2 != 0))) return fault;
`ifdef ADDR_RANGE_CHECK_EN
    if (mem && !addr_ok(is_st, w, a)) return fault;
`endif
    return 0;
  endfunction

  task automatic model_edge();
    int unsigned ex;
    if (reset || flush) begin
      {x_pc, x_res, x_sd} = '0;
      {x_bd, x_load, x_store, x_mwe, x_rwe} = '0;
      x_exc = 0; x_rd = 0; x_width = 0;
    end else if (!stall) begin
      ex      = model_exc();
      x_pc    = e_pc;   x_bd = e_bd;   x_res = e_alu_res; x_sd = e_st_data;
      x_load  = e_load; x_store = e_store && !e_load;
      x_width = e_width; x_rd = e_rd_addr; x_exc = ex[4:0];
      x_mwe   = x_store && ex == 0;
      x_rwe   = e_rd_addr != 0 && ex == 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},    m_pc, x_pc);
    check({tag, ".bd"},    m_bd, x_bd);
    check({tag, ".exc"},   m_exc, x_exc);
    check({tag, ".res"},   m_alu_res, x_res);
    check({tag, ".load"},  m_load, x_load);
    check({tag, ".store"}, m_store, x_store);
    check({tag, ".width"}, m_width, x_width);
    check({tag, ".sdata"}, m_st_data, x_sd);
    check({tag, ".rd"},    m_rd_addr, x_rd);
    check({tag, ".memwe"}, m_mem_we, x_mwe);
    check({tag, ".rfwe"},  m_rf_we, x_rwe);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    e_pc = 32'h0000_3000; e_bd = 0; e_exc = 0; e_alu_res = 0; e_alu_ov = 0;
    e_arith_ov = 0; e_load = 0; e_store = 0; e_width = 0; e_st_data = 0; e_rd_addr = 0;
  endtask

  task automatic mem_op(input bit ld, input logic [1:0] w, input logic [31:0] a);
    idle();
    e_load = ld; e_store = !ld; e_width = w; e_alu_res = a;
    e_rd_addr = ld ? 5'd9 : 5'd0; e_st_data = 32'hCAFE_F00D;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return $urandom_range(0, 32'h3003);
      2:       return 32'h7F00 + $urandom_range(0, 15);
      3:       return 32'h7F10 + $urandom_range(0, 15);
      4:       return 32'h7F1C + $urandom_range(0, 11);
      default: return 32'hFFFF_FFF0 + $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    idle();
    // Reset wins over stall.
    reset = 1; stall = 1;
    e_pc = 32'h1234_5678; e_rd_addr = 5'd3; e_store = 1;
    step("reset");
    check("reset.rfwe_const", m_rf_we, 1'b0);
    check("reset.memwe_const", m_mem_we, 1'b0);

    // Trapping add overflow vs addu.
    idle(); e_alu_res = 32'h8000_0000; e_alu_ov = 1; e_arith_ov = 1; e_rd_addr = 5'd8;
    step("add_ov");
    check("add_ov.exc_const", m_exc, 5'd12);
    check("add_ov.rfwe_const", m_rf_we, 1'b0);
    e_arith_ov = 0;
    step("addu");
    check("addu.exc_const", m_exc, 5'd0);
    check("addu.rfwe_const", m_rf_we, 1'b1);

    // Alignment faults.
    mem_op(1, 2'd0, 32'h0000_0102); step("lw_mis");
    check("lw_mis.exc_const", m_exc, 5'd4);
    mem_op(0, 2'd1, 32'h0000_0101); step("sh_mis");
    check("sh_mis.exc_const", m_exc, 5'd5);
    check("sh_mis.memwe_const", m_mem_we, 1'b0);
    mem_op(0, 2'd2, 32'h0000_0103); step("sb_ok");
    check("sb_ok.exc_const", m_exc, 5'd0);
    check("sb_ok.memwe_const", m_mem_we, 1'b1);

    // Earlier exception wins, pc/bd kept; then stall holds.
    idle(); e_exc = 5'd10; e_alu_ov = 1; e_arith_ov = 1; e_pc = 32'h0000_4004; e_bd = 1;
    e_rd_addr = 5'd2;
    step("ri");
    check("ri.exc_const", m_exc, 5'd10);
    check("ri.pc_const", m_pc, 32'h0000_4004);
    for (int i = 0; i < 3; i++) begin
      stall = 1; e_exc = 0; e_pc = 32'h0000_5000 + i; e_alu_res = $urandom; e_rd_addr = 5'd7;
      step("stall");
      check("stall.exc_const", m_exc, 5'd10);
    end

    // Flush beats stall.
    mem_op(0, 2'd0, 32'h0000_0100); flush = 1; stall = 1;
    step("flush");
    check("flush.pc_const", m_pc, 32'd0);
    check("flush.memwe_const", m_mem_we, 1'b0);

    // Load+store together behaves as a load; wrap-around address.
    mem_op(1, 2'd0, 32'h0000_0103); e_store = 1; step("ldst");
    check("ldst.exc_const", m_exc, 5'd4);
    mem_op(1, 2'd0, 32'hFFFF_FFFC); step("wrap");

`ifdef ADDR_RANGE_CHECK_EN
    mem_op(0, 2'd0, 32'h0000_7F08); step("sw_cnt");
    check("sw_cnt.exc_const", m_exc, 5'd5);
    mem_op(1, 2'd0, 32'h0000_7F08); step("lw_cnt");
    check("lw_cnt.exc_const", m_exc, 5'd0);
    mem_op(1, 2'd2, 32'h0000_7F00); step("lb_tc");
    check("lb_tc.exc_const", m_exc, 5'd4);
    mem_op(1, 2'd0, 32'h0000_3000); step("lw_dm_end");
    check("lw_dm_end.exc_const", m_exc, 5'd4);
`else
    check("wrap.exc_const", m_exc, 5'd0);
    mem_op(1, 2'd0, 32'h0000_3000); step("lw_dm_end");
    check("lw_dm_end.exc_const", m_exc, 5'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      flush      = ($urandom_range(0, 99) < 10);
      stall      = ($urandom_range(0, 99) < 20);
      e_pc       = $urandom;
      e_bd       = $urandom_range(0, 1);
      e_exc      = ($urandom_range(0, 9) < 8) ? 5'd0 : 5'($urandom_range(1, 31));
      e_alu_res  = rand_addr();
      e_alu_ov   = ($urandom_range(0, 9) < 2);
      e_arith_ov = ($urandom_range(0, 9) < 3);
      e_load     = ($urandom_range(0, 9) < 4);
      e_store    = ($urandom_range(0, 9) < 4);
      e_width    = 2'($urandom_range(0, 2));
      e_st_data  = $urandom;
      e_rd_addr  = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
